// File: rtl/poolb_group_sequencer_if.sv
// Handshake and buffer bus of the 2x2 max-pool group sequencer.
// master = sequencer side, slave = buffers / neighbour layers.
interface poolb_group_sequencer_if #(
  parameter int AW_IFM  = 10,
  parameter int AW_NEXT = 8,
  parameter int SEL_W   = 3
);
  logic               start_from_previous;
  logic               conv_ready;
  logic               end_from_next;
  logic               end_to_previous;
  logic               ifm_enable_read_A_current;
  logic               ifm_enable_read_B_current;
  logic [AW_IFM-1:0]  ifm_address_read_A_current;
  logic [AW_IFM-1:0]  ifm_address_read_B_current;
  logic               fifo_enable;
  logic               pool_enable;
  logic               ifm_enable_write_next;
  logic [AW_NEXT-1:0] ifm_address_write_next;
  logic               start_to_next;
  logic [SEL_W-1:0]   ifm_sel_next;

  modport master (
    input  start_from_previous,
    input  conv_ready,
    input  end_from_next,
    output end_to_previous,
    output ifm_enable_read_A_current,
    output ifm_enable_read_B_current,
    output ifm_address_read_A_current,
    output ifm_address_read_B_current,
    output fifo_enable,
    output pool_enable,
    output ifm_enable_write_next,
    output ifm_address_write_next,
    output start_to_next,
    output ifm_sel_next
  );

  modport slave (
    output start_from_previous,
    output conv_ready,
    output end_from_next,
    input  end_to_previous,
    input  ifm_enable_read_A_current,
    input  ifm_enable_read_B_current,
    input  ifm_address_read_A_current,
    input  ifm_address_read_B_current,
    input  fifo_enable,
    input  pool_enable,
    input  ifm_enable_write_next,
    input  ifm_address_write_next,
    input  start_to_next,
    input  ifm_sel_next
  );
endinterface

// File: rtl/poolb_group_sequencer.sv
// Max-pool group sequencer: reads one ifm group as A/B row pairs,
// strobes the pool datapath and writes the pooled map downstream.
module poolb_group_sequencer #(
  parameter int IFM_SIZE        = 32,
  parameter int IFM_DEPTH       = 16,
  parameter int KERNAL_SIZE     = 2,
  parameter int NUMBER_OF_UNITS = 3,
  parameter int IFM_SIZE_NEXT   =
    (IFM_SIZE - KERNAL_SIZE) / 2 + 1,
  parameter int GROUPS          =
    (IFM_DEPTH + NUMBER_OF_UNITS - 1)
    / NUMBER_OF_UNITS,
  parameter int ADDRESS_SIZE_IFM =
    $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_NEXT_IFM =
    $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
  parameter int SEL_W =
    (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input logic                     clk,
  input logic                     reset,
  poolb_group_sequencer_if.master bus
);

  localparam int N  = IFM_SIZE_NEXT;
  localparam int NN = N * N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = ADDRESS_SIZE_IFM;
  localparam int WW = ADDRESS_SIZE_NEXT_IFM;

  localparam logic [IW-1:0] LAST_IDX =
    IW'(N - 1);
  localparam logic [WW-1:0] LAST_WR =
    WW'(NN - 1);
  localparam logic [SEL_W-1:0] LAST_GRP =
    SEL_W'(GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t state;

  logic [IW-1:0]    row_i;
  logic [IW-1:0]    col_j;
  logic             phase;
  logic             pending;
  logic             next_busy;
  logic [SEL_W-1:0] group;

  logic             rd_en;
  logic [AW-1:0]    addr_a;
  logic [AW-1:0]    addr_b;
  logic             fifo_en;
  logic             pool_en;
  logic             wr_en;
  logic [WW-1:0]    wr_addr;
  logic             end_prev;
  logic             start_next;
  logic [SEL_W-1:0] sel_next;

  logic             accept;
  logic             last_read;
  logic             last_write;
  logic             nxt_phase;
  logic [IW-1:0]    nxt_col;
  logic [IW-1:0]    nxt_row;
  logic [AW-1:0]    nxt_a;
  logic [AW-1:0]    nxt_b;

  assign accept = pending
                & bus.conv_ready
                & ~next_busy;

  assign last_read = phase
                   & (row_i == LAST_IDX)
                   & (col_j == LAST_IDX);

  assign last_write = wr_en
                    & (wr_addr == LAST_WR);

  // Step the window: c0 -> c1, then next column, row on wrap.
  always_comb begin
    nxt_phase = ~phase;
    nxt_col   = col_j;
    nxt_row   = row_i;
    if (phase) begin
      if (col_j == LAST_IDX) begin
        nxt_col = '0;
        nxt_row = row_i + IW'(1);
      end else begin
        nxt_col = col_j + IW'(1);
      end
    end
  end

  // Even row of the pair feeds A; B sits one map row below.
  always_comb begin
    nxt_a = AW'(nxt_row) * AW'(2 * IFM_SIZE)
          + (AW'(nxt_col) << 1)
          + AW'(nxt_phase);
    nxt_b = nxt_a + AW'(IFM_SIZE);
  end

  // Group FSM with read, pipeline and handover registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      row_i      <= '0;
      col_j      <= '0;
      phase      <= 1'b0;
      pending    <= 1'b0;
      next_busy  <= 1'b0;
      group      <= '0;
      rd_en      <= 1'b0;
      addr_a     <= '0;
      addr_b     <= '0;
      fifo_en    <= 1'b0;
      pool_en    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      end_prev   <= 1'b0;
      start_next <= 1'b0;
      sel_next   <= '0;
    end else begin
      end_prev   <= 1'b0;
      start_next <= 1'b0;
      fifo_en    <= rd_en;
      pool_en    <= rd_en & phase;
      wr_en      <= pool_en;
      if (wr_en && !last_write) begin
        wr_addr <= wr_addr + WW'(1);
      end
      if (bus.end_from_next) begin
        next_busy <= 1'b0;
      end
      if (bus.start_from_previous) begin
        pending <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            state   <= READ;
            rd_en   <= 1'b1;
            row_i   <= '0;
            col_j   <= '0;
            phase   <= 1'b0;
            addr_a  <= '0;
            addr_b  <= AW'(IFM_SIZE);
            wr_addr <= '0;
            pending <= bus.start_from_previous;
          end
        end
        READ: begin
          if (last_read) begin
            state    <= DRAIN;
            rd_en    <= 1'b0;
            end_prev <= 1'b1;
          end else begin
            phase  <= nxt_phase;
            col_j  <= nxt_col;
            row_i  <= nxt_row;
            addr_a <= nxt_a;
            addr_b <= nxt_b;
          end
        end
        DRAIN: begin
          if (last_write) begin
            state      <= DONE;
            start_next <= 1'b1;
            sel_next   <= group;
            next_busy  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          if (group == LAST_GRP) begin
            group <= '0;
          end else begin
            group <= group + SEL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ifm_enable_read_A_current  = rd_en;
  assign bus.ifm_enable_read_B_current  = rd_en;
  assign bus.ifm_address_read_A_current = addr_a;
  assign bus.ifm_address_read_B_current = addr_b;
  assign bus.fifo_enable                = fifo_en;
  assign bus.pool_enable                = pool_en;
  assign bus.ifm_enable_write_next      = wr_en;
  assign bus.ifm_address_write_next     = wr_addr;
  assign bus.end_to_previous            = end_prev;
  assign bus.start_to_next              = start_next;
  assign bus.ifm_sel_next               = sel_next;

endmodule

// File: tb/tb_poolb_group_sequencer.sv
// Bench for poolb_group_sequencer, small 4x4 / 2-group configuration.
// Timeline reference model plus a cycle table and corner sequences.
module tb_poolb_group_sequencer;

  localparam int S   = 4;
  localparam int D   = 4;
  localparam int U   = 3;
  localparam int N   = (S - 2) / 2 + 1;
  localparam int NN  = N * N;
  localparam int G   = (D + U - 1) / U;
  localparam int AWI = $clog2(S * S);
  localparam int AWN = $clog2(NN);
  localparam int SW  = (G > 1) ? $clog2(G) : 1;
  localparam int VW  = 2 * AWI + AWN + SW + 8;
  localparam int RW  = 2 * AWI + AWN + 5;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  poolb_group_sequencer_if #(
    .AW_IFM (AWI),
    .AW_NEXT(AWN),
    .SEL_W  (SW)
  ) bus ();

  poolb_group_sequencer #(
    .IFM_SIZE       (S),
    .IFM_DEPTH      (D),
    .KERNAL_SIZE    (2),
    .NUMBER_OF_UNITS(U)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit s;
    bit cr;
    bit rd;
    int a;
    int b;
    bit wr;
    int wa;
    bit ep;
    bit st;
  } row_t;

  row_t tbl[14];

  int checks = 0;
  int fails  = 0;

  int cyc = 0;
  int t0 = 0;
  bit act, pend, nbusy;
  int grp, gidx, hsel, ha, hb;
  int n_rd = 0;
  int n_ep = 0;
  int n_st = 0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               name, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    act = 0; pend = 0; nbusy = 0;
    grp = 0; gidx = 0; hsel = 0;
    ha = 0; hb = 0;
  endfunction

  function automatic bit accept_now(bit cr);
    bit idle;
    idle = !act || (cyc - t0) >= 2 * NN + 4;
    return idle && pend && cr && !nbusy;
  endfunction

  // Expected outputs of the current cycle, from the group timeline.
  function automatic logic [VW-1:0] model_out(output bit ew);
    int k;
    bit rd, ff, pl, wr, ep, st;
    int wa;
    k  = cyc - t0;
    rd = act && k >= 1 && k <= 2 * NN;
    if (rd) begin
      int idx, i, j;
      idx = k - 1;
      i = idx / (2 * N);
      j = (idx / 2) % N;
      ha = 2 * i * S + 2 * j + idx % 2;
      hb = ha + S;
    end
    ff = act && k >= 2 && k <= 2 * NN + 1;
    pl = ff && k >= 3 && (k % 2 == 1);
    wr = act && k >= 4 && k <= 2 * NN + 2
         && (k % 2 == 0);
    wa = wr ? (k - 4) / 2 : 0;
    ep = act && k == 2 * NN + 1;
    st = act && k == 2 * NN + 3;
    if (st) hsel = gidx;
    ew = wr;
    return {rd, rd, AWI'(ha), AWI'(hb), ff, pl,
            wr, AWN'(wa), ep, st, SW'(hsel)};
  endfunction

  function automatic void model_step(bit s, bit cr,
                                     bit ef);
    int k;
    bit acc;
    k = cyc - t0;
    acc = accept_now(cr);
    if (act && k == 2 * NN + 3) begin
      grp = (grp + 1) % G;
      nbusy = 1;
    end
    if (ef) nbusy = 0;
    if (acc) begin
      act = 1; t0 = cyc; gidx = grp; pend = 0;
    end
    if (s) pend = 1;
    cyc++;
  endfunction

  function automatic logic [VW-1:0] dut_vec(bit ew);
    logic [AWN-1:0] wa;
    wa = ew ? bus.ifm_address_write_next : '0;
    return {bus.ifm_enable_read_A_current,
            bus.ifm_enable_read_B_current,
            bus.ifm_address_read_A_current,
            bus.ifm_address_read_B_current,
            bus.fifo_enable, bus.pool_enable,
            bus.ifm_enable_write_next, wa,
            bus.end_to_previous, bus.start_to_next,
            bus.ifm_sel_next};
  endfunction

  task automatic apply(input bit s, input bit cr,
                       input bit ef);
    bus.start_from_previous = s;
    bus.conv_ready = cr;
    bus.end_from_next = ef;
    model_step(s, cr, ef);
  endtask

  task automatic observe();
    logic [VW-1:0] e;
    bit ew;
    e = model_out(ew);
    check("cycle_outputs", 32'(dut_vec(ew)), 32'(e));
    if (bus.ifm_enable_read_A_current) n_rd++;
    if (bus.end_to_previous) n_ep++;
    if (bus.start_to_next) n_st++;
  endtask

  task automatic tick(input bit s, input bit cr,
                      input bit ef);
    @(negedge clk);
    observe();
    apply(s, cr, ef);
  endtask

  task automatic tick_row(input row_t r);
    logic [RW-1:0] e, g;
    logic [AWN-1:0] wa;
    @(negedge clk);
    observe();
    wa = r.wr ? bus.ifm_address_write_next : '0;
    e = {r.rd, r.rd, AWI'(r.a), AWI'(r.b), r.wr,
         r.wr ? AWN'(r.wa) : AWN'(0), r.ep, r.st};
    g = {bus.ifm_enable_read_A_current,
         bus.ifm_enable_read_B_current,
         bus.ifm_address_read_A_current,
         bus.ifm_address_read_B_current,
         bus.ifm_enable_write_next, wa,
         bus.end_to_previous, bus.start_to_next};
    check("table_row", 32'(g), 32'(e));
    apply(r.s, r.cr, 1'b0);
  endtask

  task automatic set_row(input int n, input bit s,
                         input bit rd, input int a,
                         input int b, input bit wr,
                         input int wa, input bit ep,
                         input bit st);
    tbl[n] = '{s: s, cr: 1'b1, rd: rd, a: a, b: b,
               wr: wr, wa: wa, ep: ep, st: st};
  endtask

  initial begin
    int r0, e0, s0;
    set_row(0,  1, 0,  0,  0, 0, 0, 0, 0);
    set_row(1,  0, 0,  0,  0, 0, 0, 0, 0);
    set_row(2,  0, 1,  0,  4, 0, 0, 0, 0);
    set_row(3,  0, 1,  1,  5, 0, 0, 0, 0);
    set_row(4,  0, 1,  2,  6, 0, 0, 0, 0);
    set_row(5,  0, 1,  3,  7, 1, 0, 0, 0);
    set_row(6,  0, 1,  8, 12, 0, 0, 0, 0);
    set_row(7,  0, 1,  9, 13, 1, 1, 0, 0);
    set_row(8,  0, 1, 10, 14, 0, 0, 0, 0);
    set_row(9,  0, 1, 11, 15, 1, 2, 0, 0);
    set_row(10, 0, 0, 11, 15, 0, 0, 1, 0);
    set_row(11, 0, 0, 11, 15, 1, 3, 0, 0);
    set_row(12, 0, 0, 11, 15, 0, 0, 0, 1);
    set_row(13, 0, 0, 11, 15, 0, 0, 0, 0);

    bus.start_from_previous = 1'b0;
    bus.conv_ready = 1'b0;
    bus.end_from_next = 1'b0;
    model_reset();

    repeat (2) tick(0, 0, 0);
    reset = 1'b1;

    // Basic group: addresses, writes, end/start timing.
    for (int n = 0; n < 14; n++) tick_row(tbl[n]);

    // Next layer busy holds the second group.
    r0 = n_rd;
    tick(1, 1, 0);
    repeat (6) tick(0, 1, 0);
    check("held_while_busy", n_rd - r0, 0);
    tick(0, 1, 1);
    repeat (2 * NN + 5) tick(0, 1, 0);
    check("sel_group1", 32'(bus.ifm_sel_next), 1);
    tick(1, 1, 1);
    repeat (2 * NN + 5) tick(0, 1, 0);
    check("sel_wrap", 32'(bus.ifm_sel_next), 0);

    // conv_ready gates the accept only.
    tick(0, 0, 1);
    tick(1, 0, 0);
    r0 = n_rd;
    repeat (5) tick(0, 0, 0);
    check("no_read_wo_ready", n_rd - r0, 0);
    tick(0, 1, 0);
    tick(0, 0, 0);
    check("read_after_ready",
          32'(bus.ifm_enable_read_A_current), 1);
    repeat (2 * NN + 3) tick(0, 0, 0);

    // Extra start pulses while one is pending collapse.
    tick(0, 1, 1);
    s0 = n_st;
    tick(1, 1, 0);
    tick(0, 1, 0);
    tick(1, 1, 0);
    tick(0, 1, 0);
    tick(1, 1, 0);
    repeat (2 * NN + 1) tick(0, 1, 0);
    tick(0, 1, 1);
    repeat (2 * NN + 5) tick(0, 1, 0);
    tick(0, 1, 1);
    repeat (2 * NN + 6) tick(0, 1, 0);
    check("single_pending", n_st - s0, 2);

    // Asynchronous reset at t5 aborts the group.
    tick(0, 1, 1);
    tick(1, 1, 0);
    repeat (6) tick(0, 1, 0);
    #2 reset = 1'b0;
    #1 check("async_reset", 32'(dut_vec(1'b1)), 0);
    model_reset();
    e0 = n_ep;
    s0 = n_st;
    repeat (2) tick(0, 1, 0);
    reset = 1'b1;
    repeat (12) tick(0, 1, 0);
    check("abort_no_end", n_ep - e0, 0);
    check("abort_no_start", n_st - s0, 0);
    tick(1, 1, 0);
    repeat (2 * NN + 5) tick(0, 1, 0);

    // Random traffic against the timeline model.
    for (int c = 0; c < 3000; c++) begin
      bit cr, s, ef;
      cr = ($urandom_range(0, 3) != 0);
      s  = accept_now(cr) ? 1'b0
           : ($urandom_range(0, 15) == 0);
      ef = nbusy && ($urandom_range(0, 7) == 0);
      tick(s, cr, ef);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
